// File: rtl/stack_unit.sv
// LIFO word stack for the stack calculator: push/pop/swap/dup/over/rot/replace with sticky error flags.
// Optional synchronous clear port `clr` is enabled by defining STACK_UNIT_CLEAR_EN.
module stack_unit #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef STACK_UNIT_CLEAR_EN
  input  logic             clr,
`endif
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] in_word,
  input  logic             err_clr,
  output logic [WIDTH-1:0] top_word,
  output logic [WIDTH-1:0] second_word,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_PUSH    = 3'b001,
    OP_POP     = 3'b010,
    OP_SWAP    = 3'b011,
    OP_DUP     = 3'b100,
    OP_OVER    = 3'b101,
    OP_ROT     = 3'b110,
    OP_REPLACE = 3'b111
  } op_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] stack_reg  [DEPTH];
  logic [WIDTH-1:0] stack_next [DEPTH];
  logic [WIDTH-1:0] shift_dn   [DEPTH];
  logic [WIDTH-1:0] shift_up   [DEPTH];
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;

  op_t              op;
  logic [1:0]       need;
  logic             grow;
  logic             ovf_set;
  logic             udf_set;

  assign op = op_t'(op_code);

  // Shifted views of the stack; vacated slots fill with zero, slot 0 of shift_dn is overwritten by the op.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
      if (gi == 0) begin : g_first
        assign shift_dn[gi] = '0;
      end else begin : g_rest
        assign shift_dn[gi] = stack_reg[gi-1];
      end
      if (gi == DEPTH - 1) begin : g_last
        assign shift_up[gi] = '0;
      end else begin : g_body
        assign shift_up[gi] = stack_reg[gi+1];
      end
    end
  endgenerate

  always_comb begin
    stack_next = stack_reg;
    count_next = count_reg;
    grow       = 1'b0;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;

    case (op)
      OP_POP, OP_DUP:              need = 2'd1;
      OP_SWAP, OP_OVER, OP_REPLACE: need = 2'd2;
      OP_ROT:                      need = 2'd3;
      default:                     need = 2'd0;
    endcase

    if (op_valid && op != OP_NOP) begin
      if (count_reg < CNT_W'(need)) begin
        udf_set = 1'b1;
      end else begin
        case (op)
          OP_PUSH: begin
            stack_next    = shift_dn;
            stack_next[0] = in_word;
            grow          = 1'b1;
          end
          OP_DUP: begin
            stack_next    = shift_dn;
            stack_next[0] = stack_reg[0];
            grow          = 1'b1;
          end
          OP_OVER: begin
            stack_next    = shift_dn;
            stack_next[0] = stack_reg[1];
            grow          = 1'b1;
          end
          OP_POP: begin
            stack_next = shift_up;
            count_next = count_reg - CNT_ONE;
          end
          OP_SWAP: begin
            stack_next[0] = stack_reg[1];
            stack_next[1] = stack_reg[0];
          end
          OP_ROT: begin
            stack_next[0] = stack_reg[2];
            stack_next[1] = stack_reg[0];
            stack_next[2] = stack_reg[1];
          end
          OP_REPLACE: begin
            stack_next    = shift_up;
            stack_next[0] = in_word;
            count_next    = count_reg - CNT_ONE;
          end
          default: ;
        endcase
      end
    end

    // A full stack drops its bottom entry instead of growing.
    if (grow) begin
      if (count_reg == CNT_FULL) begin
        ovf_set = 1'b1;
      end else begin
        count_next = count_reg + CNT_ONE;
      end
    end

`ifdef STACK_UNIT_CLEAR_EN
    if (clr) begin
      stack_next = '{default: '0};
      count_next = '0;
      ovf_set    = 1'b0;
      udf_set    = 1'b0;
    end
`endif

    // Setting a flag takes priority over clearing it in the same cycle.
    overflow_next  = (overflow_reg & ~err_clr) | ovf_set;
    underflow_next = (underflow_reg & ~err_clr) | udf_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stack_reg     <= '{default: '0};
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      stack_reg     <= stack_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign top_word    = stack_reg[0];
  assign second_word = stack_reg[1];
  assign count       = count_reg;
  assign empty       = (count_reg == '0);
  assign full        = (count_reg == CNT_FULL);
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit (WIDTH=4, DEPTH=8): directed plan plus random ops against a queue model.
module tb_stack_unit;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             clr;
  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] in_word;
  logic             err_clr;
  logic [WIDTH-1:0] top_word;
  logic [WIDTH-1:0] second_word;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef STACK_UNIT_CLEAR_EN
    .clr         (clr),
`endif
    .op_valid    (op_valid),
    .op_code     (op_code),
    .in_word     (in_word),
    .err_clr     (err_clr),
    .top_word    (top_word),
    .second_word (second_word),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int    top;
    int    second;
    int    cnt;
    int    emp;
    int    ful;
    int    ovf;
    int    udf;
    int    id;
  } exp_t;

  exp_t exp_q[$];
  int   m[$];          // model stack, index 0 is top
  int   m_ovf;
  int   m_udf;
  int   n_cmp;
  int   n_bad;
  int   op_id;

  function automatic void chk(string nm, int id, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s op#%0d: got %0d expected %0d", nm, id, act, req);
    end
  endfunction

  function automatic exp_t model_view(int id);
    exp_t e;
    e.top    = (m.size() > 0) ? m[0] : 0;
    e.second = (m.size() > 1) ? m[1] : 0;
    e.cnt    = m.size();
    e.emp    = (m.size() == 0) ? 1 : 0;
    e.ful    = (m.size() == DEPTH) ? 1 : 0;
    e.ovf    = m_ovf;
    e.udf    = m_udf;
    e.id     = id;
    return e;
  endfunction

  function automatic void compare_all(exp_t e);
    chk("top", e.id, int'(top_word), e.top);
    chk("second", e.id, int'(second_word), e.second);
    chk("count", e.id, int'(count), e.cnt);
    chk("empty", e.id, int'(empty), e.emp);
    chk("full", e.id, int'(full), e.ful);
    chk("overflow", e.id, int'(overflow), e.ovf);
    chk("underflow", e.id, int'(underflow), e.udf);
  endfunction

  // Reference behaviour: list operations on a queue, sized by the operand rules.
  function automatic void model_step(bit v, int code, int w, bit ec, bit cl);
    int a, b, c;
    bit os, us;
    os = 0;
    us = 0;
    if (cl) begin
      m.delete();
    end else if (v) begin
      case (code)
        1: m.push_front(w);
        2: if (m.size() < 1) us = 1; else void'(m.pop_front());
        3: if (m.size() < 2) us = 1;
           else begin a = m[0]; m[0] = m[1]; m[1] = a; end
        4: if (m.size() < 1) us = 1; else m.push_front(m[0]);
        5: if (m.size() < 2) us = 1; else m.push_front(m[1]);
        6: if (m.size() < 3) us = 1;
           else begin a = m[0]; b = m[1]; c = m[2]; m[0] = c; m[1] = a; m[2] = b; end
        7: if (m.size() < 2) us = 1;
           else begin void'(m.pop_front()); void'(m.pop_front()); m.push_front(w); end
        default: ;
      endcase
      if (m.size() > DEPTH) begin
        void'(m.pop_back());
        os = 1;
      end
    end
    m_ovf = (ec ? 0 : m_ovf) | int'(os);
    m_udf = (ec ? 0 : m_udf) | int'(us);
  endfunction

  task automatic do_op(bit v, int code, int w, bit ec, bit cl);
    @(negedge clk);
    op_valid = v;
    op_code  = code[2:0];
    in_word  = w[WIDTH-1:0];
    err_clr  = ec;
    clr      = cl;
    op_id++;
    model_step(v, code, w, ec, cl);
    exp_q.push_back(model_view(op_id));
  endtask

  task automatic push(int w);
    do_op(1, 1, w, 0, 0);
  endtask

  task automatic op(int code);
    do_op(1, code, 0, 0, 0);
  endtask

  // Monitor: every clock edge retires the one outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare_all(e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cl_en;
    n_cmp = 0;
    n_bad = 0;
    op_id = 0;
    m_ovf = 0;
    m_udf = 0;
    cl_en = 0;
`ifdef STACK_UNIT_CLEAR_EN
    cl_en = 1;
`endif
    rst = 1'b0;
    clr = 1'b0;
    op_valid = 1'b0;
    op_code = 3'd0;
    in_word = '0;
    err_clr = 1'b0;

    // Reset acts before any clock edge.
    #3;
    compare_all(model_view(0));
    @(negedge clk);
    rst = 1'b1;

    push(3); push(5); push(9);
    op(2);
    op(2); op(2);

    push(3); push(2); push(1);
    op(6); op(3); op(5);
    op(2); op(2); op(2); op(2);

    op(2);
    do_op(0, 0, 0, 1, 0);
    push(7);
    op(3);
    do_op(1, 2, 0, 1, 0);

    for (int i = 1; i <= 8; i++) push(i);
    push(15);
    for (int i = 0; i < 8; i++) op(2);
    do_op(0, 0, 0, 1, 0);

    push(7); push(6); push(4);
    do_op(1, 7, 10, 0, 0);
    op(2); op(2);

    // Async reset asserted mid-cycle must clear outputs without a clock edge.
    push(9); push(11);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    err_clr = 1'b0;
    #2;
    rst = 1'b0;
    m.delete();
    m_ovf = 0;
    m_udf = 0;
    #1;
    compare_all(model_view(-1));
    @(negedge clk);
    rst = 1'b1;
    push(2);

    if (cl_en) begin
      push(4);
      do_op(1, 1, 6, 0, 1);
      push(5);
    end

    for (int i = 0; i < 400; i++) begin
      do_op(($urandom_range(0, 9) != 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0),
            cl_en && ($urandom_range(0, 29) == 0));
    end

    @(negedge clk);
    op_valid = 1'b0;
    err_clr = 1'b0;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("drain", op_id, exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
